shreg_ser_ctrl: RTL and testbench

Sequencer directly upstream of the 4-bit universal shift register (mux-select register: sel 00 hold, 01 shift toward T3 with zero fill at T0, 10 parallel load from U, 11 same as 01). It accepts parallel words over a valid/ready handshake and drives the register's sel and U inputs to load each word. It then shifts the word out MSB-first, observing the register's T3 output and presenting it downstream as a serial stream with valid/ready back-pressure. It also enforces a configurable inter-word gap.

---
 rtl/shreg_ser_ctrl.sv | 111 +++++++++++
 tb/tb_shreg_ser_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/shreg_ser_ctrl.sv
// Load/shift sequencer for a 4-bit universal shift register.
// Serializes accepted parallel words MSB-first with valid/ready back-pressure.
module shreg_ser_ctrl #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic [1:0]       sr_sel,
  output logic [WIDTH-1:0] sr_u,
  input  logic             sr_t3,
  output logic             tx_valid,
  output logic             tx_bit,
  input  logic             tx_ready,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'((GAP > 0) ? GAP - 1 : 0);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] word, word_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      word  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      word  <= word_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    word_nxt  = word;
    if (flush) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE:
          if (in_valid) begin
            word_nxt  = in_data;
            state_nxt = S_LOAD;
          end
        S_LOAD: begin
          state_nxt = S_SHIFT;
          cnt_nxt   = '0;
        end
        S_SHIFT:
          if (tx_ready) begin
            if (cnt == LAST_BIT) begin
              cnt_nxt   = '0;
              state_nxt = (GAP > 0) ? S_GAP : S_IDLE;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
        S_GAP:
          if (cnt == LAST_GAP) begin
            cnt_nxt   = '0;
            state_nxt = S_IDLE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // in_ready drops during flush so a word offered in that cycle is not silently lost.
  always_comb begin
    in_ready = 1'b0;
    sr_sel   = 2'b00;
    sr_u     = word;
    tx_valid = 1'b0;
    done     = 1'b0;
    busy     = (state != S_IDLE);
    if (reset) begin
      sr_u = '0;
      busy = 1'b0;
    end else if (!flush) begin
      case (state)
        S_IDLE:  in_ready = 1'b1;
        S_LOAD:  sr_sel = 2'b10;
        S_SHIFT: begin
          tx_valid = 1'b1;
          if (tx_ready) sr_sel = 2'b01;
          done = tx_ready && (cnt == LAST_BIT);
        end
        default: ;
      endcase
    end
  end

  assign tx_bit = sr_t3;

endmodule

// File: tb/tb_shreg_ser_ctrl.sv
// Bench: directed vector table, GAP=0 back-to-back sequence, and random traffic
// checked each cycle against a word/bit-count reference model for GAP=1 and GAP=0.
module tb_shreg_ser_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       flush = 1'b0;
  logic       tx_ready = 1'b0;

  logic [1:0]      rdy, vld, tbit, dn, bsy, t3;
  logic [1:0][1:0] sel;
  logic [1:0][3:0] u;
  logic [1:0][3:0] sr = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shreg_ser_ctrl #(.WIDTH(4), .GAP(1), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[0]),
    .flush(flush), .sr_sel(sel[0]), .sr_u(u[0]), .sr_t3(t3[0]), .tx_valid(vld[0]),
    .tx_bit(tbit[0]), .tx_ready(tx_ready), .done(dn[0]), .busy(bsy[0]));

  shreg_ser_ctrl #(.WIDTH(4), .GAP(0), .CNT_W(3)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[1]),
    .flush(flush), .sr_sel(sel[1]), .sr_u(u[1]), .sr_t3(t3[1]), .tx_valid(vld[1]),
    .tx_bit(tbit[1]), .tx_ready(tx_ready), .done(dn[1]), .busy(bsy[1]));

  // Behavioural 4-bit universal shift registers fed by each controller.
  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      case (sel[i])
        2'b01, 2'b11: sr[i] <= {sr[i][2:0], 1'b0};
        2'b10:        sr[i] <= u[i];
        default: ;
      endcase
  assign t3[0] = sr[0][3];
  assign t3[1] = sr[1][3];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending load, remaining bits of the held word, idle cycles left.
  int         m_pend[2];
  int         m_n[2];
  int         m_gap[2];
  logic [3:0] m_word[2];

  initial
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_n[i] = 0; m_gap[i] = 0; m_word[i] = '0;
    end

  function automatic bit m_idle(input int i);
    return (m_pend[i] == 0) && (m_n[i] == 0) && (m_gap[i] == 0);
  endfunction

  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_pend[i] = 0; m_n[i] = 0; m_gap[i] = 0; m_word[i] = '0;
      end else if (flush) begin
        m_pend[i] = 0; m_n[i] = 0; m_gap[i] = 0;
      end else if (m_idle(i)) begin
        if (in_valid) begin m_pend[i] = 1; m_word[i] = in_data; end
      end else if (m_pend[i] != 0) begin
        m_pend[i] = 0; m_n[i] = 4;
      end else if (m_n[i] > 0) begin
        if (tx_ready) begin
          m_n[i] = m_n[i] - 1;
          if (m_n[i] == 0) m_gap[i] = (i == 0) ? 1 : 0;
        end
      end else if (m_gap[i] > 0) begin
        m_gap[i] = m_gap[i] - 1;
      end
    end

  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      logic       e_ir, e_tv, e_dn, e_bs;
      logic [1:0] e_sel;
      logic [3:0] e_u;
      string      p;
      p = (i == 0) ? "m_gap1" : "m_gap0";
      if (reset) begin
        e_ir = 0; e_tv = 0; e_dn = 0; e_bs = 0; e_sel = 0; e_u = 0;
      end else begin
        e_ir  = m_idle(i) && !flush;
        e_bs  = !m_idle(i);
        e_tv  = (m_n[i] > 0) && !flush;
        e_dn  = (m_n[i] == 1) && tx_ready && !flush;
        e_u   = m_word[i];
        e_sel = flush ? 2'd0 : (m_pend[i] != 0) ? 2'd2 : ((m_n[i] > 0) && tx_ready) ? 2'd1 : 2'd0;
      end
      chk({p, "_in_ready"}, 8'(rdy[i]), 8'(e_ir));
      chk({p, "_busy"},     8'(bsy[i]), 8'(e_bs));
      chk({p, "_tx_valid"}, 8'(vld[i]), 8'(e_tv));
      chk({p, "_done"},     8'(dn[i]),  8'(e_dn));
      chk({p, "_sr_sel"},   8'(sel[i]), 8'(e_sel));
      chk({p, "_sr_u"},     8'(u[i]),   8'(e_u));
      if (e_tv) chk({p, "_tx_bit"}, 8'(tbit[i]), 8'(m_word[i][m_n[i]-1]));
    end

  typedef struct packed {
    logic       rst, iv; logic [3:0] id; logic fl, tr;
    logic       ir; logic [1:0] sel; logic [3:0] u; logic tv, tbc, tb, dn, bs;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, iv, input logic [3:0] id, input logic fl, tr,
                              input logic ir, input logic [1:0] sel, input logic [3:0] u,
                              input logic tv, tbc, tb, dn, bs);
    return '{rst, iv, id, fl, tr, ir, sel, u, tv, tbc, tb, dn, bs};
  endfunction

  int         acc, dcyc, acyc, nb;
  logic [7:0] bits;

  initial begin
    // reset, then 1010 with GAP=1
    vecs.push_back(mk(1,0,4'h0,0,1, 0,0,4'h0,0,0,0,0,0));
    vecs.push_back(mk(1,0,4'h0,0,1, 0,0,4'h0,0,0,0,0,0));
    vecs.push_back(mk(0,1,4'hA,0,1, 1,0,4'h0,0,0,0,0,0));
    vecs.push_back(mk(0,0,4'h0,0,1, 0,2,4'hA,0,0,0,0,1));
    vecs.push_back(mk(0,0,4'h0,0,1, 0,1,4'hA,1,1,1,0,1));
    vecs.push_back(mk(0,0,4'h0,0,1, 0,1,4'hA,1,1,0,0,1));
    vecs.push_back(mk(0,0,4'h0,0,1, 0,1,4'hA,1,1,1,0,1));
    vecs.push_back(mk(0,0,4'h0,0,1, 0,1,4'hA,1,1,0,1,1));
    vecs.push_back(mk(0,0,4'h0,0,1, 0,0,4'hA,0,0,0,0,1));
    // 1100 with two stall cycles after the first bit
    vecs.push_back(mk(0,1,4'hC,0,1, 1,0,4'hA,0,0,0,0,0));
    vecs.push_back(mk(0,0,4'h0,0,1, 0,2,4'hC,0,0,0,0,1));
    vecs.push_back(mk(0,0,4'h0,0,1, 0,1,4'hC,1,1,1,0,1));
    vecs.push_back(mk(0,0,4'h0,0,0, 0,0,4'hC,1,1,1,0,1));
    vecs.push_back(mk(0,0,4'h0,0,0, 0,0,4'hC,1,1,1,0,1));
    vecs.push_back(mk(0,0,4'h0,0,1, 0,1,4'hC,1,1,1,0,1));
    vecs.push_back(mk(0,0,4'h0,0,1, 0,1,4'hC,1,1,0,0,1));
    vecs.push_back(mk(0,0,4'h0,0,1, 0,1,4'hC,1,1,0,1,1));
    vecs.push_back(mk(0,0,4'h0,0,1, 0,0,4'hC,0,0,0,0,1));
    // 0111 flushed on its third bit, then 1001
    vecs.push_back(mk(0,1,4'h7,0,1, 1,0,4'hC,0,0,0,0,0));
    vecs.push_back(mk(0,0,4'h0,0,1, 0,2,4'h7,0,0,0,0,1));
    vecs.push_back(mk(0,0,4'h0,0,1, 0,1,4'h7,1,1,0,0,1));
    vecs.push_back(mk(0,0,4'h0,0,1, 0,1,4'h7,1,1,1,0,1));
    vecs.push_back(mk(0,0,4'h0,1,1, 0,0,4'h7,0,0,0,0,1));
    vecs.push_back(mk(0,1,4'h9,0,1, 1,0,4'h7,0,0,0,0,0));
    vecs.push_back(mk(0,0,4'h0,0,1, 0,2,4'h9,0,0,0,0,1));
    vecs.push_back(mk(0,0,4'h0,0,1, 0,1,4'h9,1,1,1,0,1));
    vecs.push_back(mk(0,0,4'h0,0,1, 0,1,4'h9,1,1,0,0,1));
    vecs.push_back(mk(0,0,4'h0,0,1, 0,1,4'h9,1,1,0,0,1));
    vecs.push_back(mk(0,0,4'h0,0,1, 0,1,4'h9,1,1,1,1,1));
    vecs.push_back(mk(0,0,4'h0,0,1, 0,0,4'h9,0,0,0,0,1));
    // reset in the middle of shifting 1011
    vecs.push_back(mk(0,1,4'hB,0,1, 1,0,4'h9,0,0,0,0,0));
    vecs.push_back(mk(0,0,4'h0,0,1, 0,2,4'hB,0,0,0,0,1));
    vecs.push_back(mk(0,0,4'h0,0,1, 0,1,4'hB,1,1,1,0,1));
    vecs.push_back(mk(1,0,4'h0,0,1, 0,0,4'h0,0,0,0,0,0));
    vecs.push_back(mk(0,0,4'h0,0,1, 1,0,4'h0,0,0,0,0,0));

    @(posedge clk); #1;
    for (int r = 0; r < vecs.size(); r++) begin
      reset = vecs[r].rst; in_valid = vecs[r].iv; in_data = vecs[r].id;
      flush = vecs[r].fl;  tx_ready = vecs[r].tr;
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", r), 8'(rdy[0]), 8'(vecs[r].ir));
      chk($sformatf("v%0d_sr_sel", r),   8'(sel[0]), 8'(vecs[r].sel));
      chk($sformatf("v%0d_sr_u", r),     8'(u[0]),   8'(vecs[r].u));
      chk($sformatf("v%0d_tx_valid", r), 8'(vld[0]), 8'(vecs[r].tv));
      chk($sformatf("v%0d_done", r),     8'(dn[0]),  8'(vecs[r].dn));
      chk($sformatf("v%0d_busy", r),     8'(bsy[0]), 8'(vecs[r].bs));
      if (vecs[r].tbc) chk($sformatf("v%0d_tx_bit", r), 8'(tbit[0]), 8'(vecs[r].tb));
      @(posedge clk); #1;
    end

    // GAP=0 back-to-back: F then 5 with in_valid held high
    reset = 0; flush = 0; tx_ready = 1; in_valid = 1; in_data = 4'hF;
    acc = 0; dcyc = -1; acyc = -1; nb = 0; bits = '0;
    for (int c = 0; c < 40 && nb < 8; c++) begin
      @(negedge clk);
      if (rdy[1] && in_valid) begin acc++; if (acc == 2) acyc = c; end
      if (vld[1]) begin bits = {bits[6:0], tbit[1]}; nb++; end
      if (dn[1] && dcyc < 0) dcyc = c;
      @(posedge clk); #1;
      if (acc == 1) in_data = 4'h5;
      if (acc >= 2) in_valid = 0;
    end
    chk("b2b_nbits",    8'(nb),   8'd8);
    chk("b2b_bits",     bits,     8'hF5);
    chk("b2b_done_cyc", 8'(dcyc), 8'd5);
    chk("b2b_accept",   8'(acyc), 8'(dcyc + 1));

    // random traffic; the models check every cycle
    for (int c = 0; c < 800; c++) begin
      reset    = ($urandom_range(0, 99) < 2);
      flush    = ($urandom_range(0, 99) < 4);
      in_valid = ($urandom_range(0, 99) < 60);
      tx_ready = ($urandom_range(0, 99) < 70);
      in_data  = 4'($urandom);
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
